// File: rtl/fifo_drain_ser.sv
// Drains a FIFO one word at a time and sends each word LSB-first with start/stop framing.
// Define FIFO_DRAIN_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_drain_ser #(
    parameter int DATA_W = 6,
    parameter int RD_LAT = 1,
    parameter int GAP    = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rdempty,
    input  logic [DATA_W-1:0] q,
    output logic              rdreq,
    output logic              ser_out,
    output logic              busy,
    output logic              word_done,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_START,
        S_DATA,
`ifdef FIFO_DRAIN_PARITY_EN
        S_PAR,
`endif
        S_STOP,
        S_GAP
    } state_t;

    // One shared counter times the read latency, the data bits and the gap.
    localparam int CMAX = (DATA_W > GAP) ? ((DATA_W > RD_LAT) ? DATA_W : RD_LAT)
                                         : ((GAP > RD_LAT) ? GAP : RD_LAT);
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] LAT_LAST  = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? GAP - 1 : 0);

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic signed [DATA_W-1:0] shift;

`ifdef FIFO_DRAIN_PARITY_EN
    logic par;

    function automatic logic even_parity(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shift     <= '0;
            rdreq     <= 1'b0;
            ser_out   <= 1'b1;
            busy      <= 1'b0;
            word_done <= 1'b0;
            word_cnt  <= '0;
`ifdef FIFO_DRAIN_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && !rdempty) begin
                        state <= S_REQ;
                        rdreq <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                    rdreq <= 1'b0;
                    cnt   <= '0;
                end
                // q becomes valid on the last WAIT cycle; capture it and drive the start bit.
                S_WAIT: begin
                    if (cnt == LAT_LAST) begin
                        state   <= S_START;
                        shift   <= q;
                        ser_out <= 1'b0;
`ifdef FIFO_DRAIN_PARITY_EN
                        par     <= even_parity(q);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    state   <= S_DATA;
                    ser_out <= shift[0];
                    shift   <= shift >>> 1;
                    cnt     <= '0;
                end
                S_DATA: begin
                    if (cnt == DATA_LAST) begin
`ifdef FIFO_DRAIN_PARITY_EN
                        state     <= S_PAR;
                        ser_out   <= par;
`else
                        state     <= S_STOP;
                        ser_out   <= 1'b1;
                        word_done <= 1'b1;
`endif
                    end else begin
                        ser_out <= shift[0];
                        shift   <= shift >>> 1;
                        cnt     <= cnt + 1'b1;
                    end
                end
`ifdef FIFO_DRAIN_PARITY_EN
                S_PAR: begin
                    state     <= S_STOP;
                    ser_out   <= 1'b1;
                    word_done <= 1'b1;
                end
`endif
                S_STOP: begin
                    word_done <= 1'b0;
                    word_cnt  <= word_cnt + 1'b1;
                    cnt       <= '0;
                    if (GAP == 0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_ser.sv
// Bench for fifo_drain_ser: FIFO read-port model, frame decoder and scoreboard of expected words.
module tb_fifo_drain_ser;

    localparam int DATA_W = 6;
    localparam int RD_LAT = 1;
    localparam int GAP    = 2;
    localparam int CNT_W  = 8;
`ifdef FIFO_DRAIN_PARITY_EN
    localparam int FRAME = DATA_W + 3;
`else
    localparam int FRAME = DATA_W + 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              rdempty;
    logic [DATA_W-1:0] q;
    logic              rdreq;
    logic              ser_out;
    logic              busy;
    logic              word_done;
    logic [CNT_W-1:0]  word_cnt;

    fifo_drain_ser #(.DATA_W(DATA_W), .RD_LAT(RD_LAT), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .rdempty(rdempty), .q(q),
        .rdreq(rdreq), .ser_out(ser_out), .busy(busy), .word_done(word_done), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] w;
    } pend_t;

    logic [DATA_W-1:0] fifo[$];
    logic [DATA_W-1:0] exp_q[$];
    pend_t             pend[$];
    pend_t             ptmp;
    logic [DATA_W-1:0] wtmp;
    logic [DATA_W-1:0] mword;
    int mpos      = -1;
    int mstart    = 0;
    int last_req  = -1000;
    int model_cnt = 0;
    int req_count = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fifo.push_back(w);
        exp_q.push_back(w);
        rdempty = 1'b0;
    endtask

    // FIFO read port and frame monitor, both evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            mpos      = -1;
            model_cnt = 0;
            last_req  = -1000;
            q         = DATA_W'($urandom);
        end else begin
            if (rdreq) begin
                req_count++;
                check("no_underflow", fifo.size() > 0, 1);
                if (last_req >= 0)
                    check("req_spacing", (cyc - last_req) >= FRAME + GAP + 2, 1);
                last_req = cyc;
                if (fifo.size() > 0) begin
                    wtmp = fifo.pop_front();
                    pend.push_back('{cyc + RD_LAT, wtmp});
                end
            end
            rdempty = (fifo.size() == 0);
            if (pend.size() > 0 && pend[0].due == cyc) begin
                ptmp = pend.pop_front();
                q    = ptmp.w;
            end else begin
                q = DATA_W'($urandom);
            end

            check("word_cnt", word_cnt, model_cnt);
            if (mpos < 0) begin
                check("word_done_outside_stop", word_done, 0);
                if (!busy) check("idle_line_high", ser_out, 1);
                if (ser_out == 1'b0) begin
                    check("start_latency", cyc - last_req, RD_LAT + 1);
                    check("busy_in_frame", busy, 1);
                    mpos   = 0;
                    mstart = cyc;
                end
            end else if (mpos < DATA_W) begin
                check("word_done_in_data", word_done, 0);
                mword[mpos] = ser_out;
                mpos++;
            end
`ifdef FIFO_DRAIN_PARITY_EN
            else if (mpos == DATA_W) begin
                check("parity_bit", ser_out, ^mword);
                check("word_done_in_parity", word_done, 0);
                mpos++;
            end
`endif
            else begin
                check("stop_bit", ser_out, 1);
                check("word_done_stop", word_done, 1);
                check("frame_len", cyc - mstart + 1, FRAME);
                if (exp_q.size() == 0) check("unexpected_word_count", exp_q.size(), 1);
                else                   check("data_word", mword, exp_q.pop_front());
                model_cnt = (model_cnt + 1) % (1 << CNT_W);
                mpos = -1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_within_budget", n < budget, 1);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!rdreq && n < budget);
        check("rdreq_seen", rdreq, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_req, bad_busy, bad_line;
        rst = 1'b1; en = 1'b0; rdempty = 1'b1; q = '0;
        repeat (2) @(negedge clk); #1;
        check("rst_rdreq", rdreq, 0);
        check("rst_ser_out", ser_out, 1);
        check("rst_busy", busy, 0);
        check("rst_word_done", word_done, 0);
        check("rst_word_cnt", word_cnt, 0);

        // single word 0x2D, cycle-accurate start
        push(6'h2D);
        en = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 check("t1_rdreq_cycle1", rdreq, 1);
        @(posedge clk); #1 check("t1_rdreq_cycle2", rdreq, 0);
        check("t1_line_cycle2", ser_out, 1);
        @(posedge clk); #1 check("t1_start_cycle3", ser_out, 0);
        drain(200);
        check("t1_word_cnt", word_cnt, 1);

        // three queued words
        do_reset();
        req_count = 0;
        push(6'h00); push(6'h3F); push(6'h15);
        drain(300);
        check("t2_req_count", req_count, 3);
        check("t2_word_cnt", word_cnt, 3);
        bad_line = 0;
        repeat (10) begin @(negedge clk); #1; if (ser_out !== 1'b1) bad_line++; end
        check("t2_line_idle_after", bad_line, 0);

        // empty FIFO with en held high
        do_reset();
        bad_req = 0; bad_busy = 0; bad_line = 0;
        repeat (50) begin
            @(negedge clk); #1;
            if (rdreq !== 1'b0)   bad_req++;
            if (busy !== 1'b0)    bad_busy++;
            if (ser_out !== 1'b1) bad_line++;
        end
        check("t3_empty_rdreq", bad_req, 0);
        check("t3_empty_busy", bad_busy, 0);
        check("t3_empty_line", bad_line, 0);
        push(6'h2A);
        @(posedge clk); #1 check("t3_rdreq_next_cycle", rdreq, 1);
        drain(200);

        // en dropped during data bit 2
        do_reset();
        push(6'h19); push(6'h26);
        wait_req(50);
        repeat (RD_LAT + 4) @(negedge clk);
        #1 en = 1'b0;
        req_count = 0;
        repeat (40) @(negedge clk);
        #1;
        check("t4_no_req_while_disabled", req_count, 0);
        check("t4_second_word_pending", exp_q.size(), 1);
        check("t4_word_cnt", word_cnt, 1);
        en = 1'b1;
        drain(200);

        // async reset during data bit 3
        do_reset();
        push(6'h05); push(6'h2E);
        wait_req(50);
        repeat (RD_LAT + 5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_ser_out", ser_out, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rdreq", rdreq, 0);
        check("t5_rst_word_cnt", word_cnt, 0);
        void'(exp_q.pop_front());
        @(negedge clk); #1 rst = 1'b0;
        drain(200);
        check("t5_word_cnt_after", word_cnt, 1);

        // word 0x07: parity bit 1 when enabled, frame length checked by the monitor
        do_reset();
        push(6'h07);
        drain(200);

        // random traffic long enough to wrap word_cnt
        do_reset();
        repeat (4000) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 9) < 3 && fifo.size() < 8) push(DATA_W'($urandom));
            en = ($urandom_range(0, 9) != 0);
        end
        en = 1'b1;
        drain(1000);
        check("rand_fifo_empty", fifo.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
